fp32_accum_ctrl: RTL and testbench
==================================

// Module: fp32_accum_ctrl
// PURPOSE
// - Co-processor reduction front end: drives the STB/BUSY initiator side of the fp32 adder and its result-consumer side.
// - Accepts a length command plus a stream of fp32 elements, computes the left fold ((x0+x1)+x2)+..., returns one fp32 sum.
// - Sits between the PCPI-side operand path and the fp32 adder; holds a 1-deep element buffer so intake overlaps adder work.
// PARAMETERS
// - LEN_W  8  width of cmd_len; max reduction length 2**LEN_W-1
// PORTS
// - clk                 in   1      clock
// - rst                 in   1      synchronous, active-high reset; also drives the adder's rst
// - cmd_start           in   1      1-cycle pulse; sampled only in IDLE
// - cmd_len             in   LEN_W  element count, sampled with cmd_start
// - data_in             in   32     fp32 element
// - data_in_STB         in   1      element valid
// - ctrl_BUSY           out  1      0 = element will be taken this edge if data_in_STB=1
// - adder_a, adder_b    out  32     adder operands (a = running acc, b = element)
// - adder_input_STB     out  1      operands valid to adder
// - adder_BUSY          in   1      adder input-side busy
// - adder_sum           in   32     adder result
// - adder_output_STB    in   1      adder result valid
// - adder_module_BUSY   out  1      0 = result taken this edge if adder_output_STB=1
// - result              out  32     final fp32 sum
// - result_STB          out  1      result valid
// - result_module_BUSY  in   1      downstream busy
// BEHAVIOUR
// - Transfer rule (all three links): data moves on a rising edge with STB=1 and BUSY=0; sender holds STB and data stable
//   until then and drops STB on the following edge. All outputs registered.
// - Reset values: ctrl_BUSY=1, adder_input_STB=0, adder_module_BUSY=1, result_STB=0, result=0, adder_a=adder_b=0; state=IDLE,
//   buffer empty, counters 0. Reset mid-operation discards acc/buffer/counters; returns to IDLE next edge; no result emitted.
// - Counters: recv_left = elements still to accept; add_left = additions still to complete.
// - ctrl_BUSY=0 only when state in {FIRST, ISSUE, WAIT}, buffer empty, recv_left!=0; goes 1 the edge after an accept.
// - IDLE: on cmd_start: cmd_len=0 -> result<=32'h00000000, DONE. Else recv_left<=cmd_len, add_left<=cmd_len-1, FIRST.
//   cmd_start outside IDLE ignored; data_in_STB in IDLE ignored (ctrl_BUSY=1).
// - FIRST: first accepted element -> acc (no adder use), recv_left--. add_left=0 -> result<=acc, DONE; else ISSUE.
// - ISSUE: when buffer full and adder_input_STB=0, load adder_a<=acc, adder_b<=buf, raise adder_input_STB. On transfer edge
//   (STB & !adder_BUSY): clear buffer, adder_input_STB<=0, adder_module_BUSY<=0, go WAIT. Buffer may refill meanwhile.
// - WAIT: on adder_output_STB & !adder_module_BUSY edge: acc<=adder_sum, add_left--, adder_module_BUSY<=1;
//   add_left becomes 0 -> result<=adder_sum, DONE; else ISSUE (immediately issues if buffer already full).
// - DONE: result_STB=1, result stable; on !result_module_BUSY edge drop result_STB, go IDLE. Held indefinitely under backpressure.
// - Element accept and adder-result capture on the same edge are both honoured. Controller never alters fp values;
//   acc passes verbatim (sign of -0 preserved for len=1).
// - Overhead: 1 cycle ISSUE entry->STB, 1 cycle WAIT->ISSUE; adder latency added per element.
// CONFIGURATION
// - FP32_ACC_PERF_EN defined: extra output perf_cycles[31:0]; counts clk edges from cmd_start accept to result transfer,
//   cleared on cmd_start, saturates at 32'hFFFFFFFF, reset 0, valid while result_STB=1.
// - Undefined: port and counter absent; all other behaviour identical.
// TESTING
// - len=3, elems 3F800000,40000000,40400000 -> result 40C00000, exactly 2 adder transactions, one result_STB.
// - len=0 -> result 00000000 within 2 cycles of cmd_start, zero adder transactions, ctrl_BUSY stays 1.
// - len=1, elem C0200000 -> result C0200000, adder_input_STB never asserted.
// - len=4 all 3F800000, data_in_STB held high, adder_BUSY stalled 5 cycles -> each elem accepted exactly once, result 40800000.
// - result_module_BUSY=1 for 10 cycles at DONE -> result_STB and result stable throughout; one transfer when released.
// - rst pulse while in WAIT -> next cycle all outputs at reset values; new len=2 3F800000+3F800000 -> 40000000.

Source files
------------

// File: rtl/fp32_accum_ctrl_if.sv
// fp32_accum_ctrl_if: element intake, adder link and result link of the fp32 reduction controller.
// FP32_ACC_PERF_EN adds the perf_cycles output.
interface fp32_accum_ctrl_if #(parameter int LEN_W = 8);
    logic             cmd_start;
    logic [LEN_W-1:0] cmd_len;
    logic [31:0]      data_in;
    logic             data_in_STB;
    logic             ctrl_BUSY;
    logic [31:0]      adder_a;
    logic [31:0]      adder_b;
    logic             adder_input_STB;
    logic             adder_BUSY;
    logic [31:0]      adder_sum;
    logic             adder_output_STB;
    logic             adder_module_BUSY;
    logic [31:0]      result;
    logic             result_STB;
    logic             result_module_BUSY;
`ifdef FP32_ACC_PERF_EN
    logic [31:0]      perf_cycles;
`endif
    modport slave (
        input  cmd_start, cmd_len, data_in, data_in_STB, adder_BUSY, adder_sum, adder_output_STB,
        input  result_module_BUSY,
        output ctrl_BUSY, adder_a, adder_b, adder_input_STB, adder_module_BUSY, result, result_STB
`ifdef FP32_ACC_PERF_EN
        , output perf_cycles
`endif
    );
    modport master (
        output cmd_start, cmd_len, data_in, data_in_STB, adder_BUSY, adder_sum, adder_output_STB,
        output result_module_BUSY,
        input  ctrl_BUSY, adder_a, adder_b, adder_input_STB, adder_module_BUSY, result, result_STB
`ifdef FP32_ACC_PERF_EN
        , input perf_cycles
`endif
    );
endinterface

// File: rtl/fp32_accum_ctrl.sv
// fp32_accum_ctrl: left-fold fp32 reduction front end driving an external STB/BUSY fp32 adder.
// FP32_ACC_PERF_EN adds a saturating cmd_start-to-result cycle counter on perf_cycles.
module fp32_accum_ctrl #(parameter int LEN_W = 8) (
    input logic              clk,
    input logic              rst,
    fp32_accum_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FIRST, ISSUE, WAIT, DONE} state_t;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] recv_left_q, recv_left_d, add_left_q, add_left_d;
    logic [31:0]      acc_q, acc_d, buf_q, buf_d, a_q, a_d, b_q, b_d, result_q, result_d;
    logic             buf_full_q, buf_full_d, ctrl_busy_q, ctrl_busy_d, in_stb_q, in_stb_d;
    logic             mod_busy_q, mod_busy_d, res_stb_q, res_stb_d;
    logic             accept, in_xfer, out_xfer, res_xfer;

    always_comb begin
        accept      = !ctrl_busy_q && bus.data_in_STB;
        in_xfer     = in_stb_q && !bus.adder_BUSY;
        out_xfer    = bus.adder_output_STB && !mod_busy_q;
        res_xfer    = res_stb_q && !bus.result_module_BUSY;
        state_d     = state_q;
        recv_left_d = recv_left_q;
        add_left_d  = add_left_q;
        acc_d       = acc_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        a_d         = a_q;
        b_d         = b_q;
        in_stb_d    = in_stb_q;
        mod_busy_d  = mod_busy_q;
        result_d    = result_q;
        res_stb_d   = res_stb_q;
        case (state_q)
            IDLE: if (bus.cmd_start) begin
                if (bus.cmd_len == '0) begin
                    result_d  = '0;
                    res_stb_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    recv_left_d = bus.cmd_len;
                    add_left_d  = bus.cmd_len - LEN_W'(1);
                    state_d     = FIRST;
                end
            end
            FIRST: if (accept) begin
                acc_d       = bus.data_in;
                recv_left_d = recv_left_q - LEN_W'(1);
                result_d    = add_left_q == '0 ? bus.data_in : result_q;
                res_stb_d   = add_left_q == '0;
                state_d     = add_left_q == '0 ? DONE : ISSUE;
            end
            ISSUE: if (in_xfer) begin
                buf_full_d = 1'b0;
                in_stb_d   = 1'b0;
                mod_busy_d = 1'b0;
                state_d    = WAIT;
            end else if (buf_full_q && !in_stb_q) begin
                a_d      = acc_q;
                b_d      = buf_q;
                in_stb_d = 1'b1;
            end
            WAIT: if (out_xfer) begin
                acc_d      = bus.adder_sum;
                add_left_d = add_left_q - LEN_W'(1);
                mod_busy_d = 1'b1;
                result_d   = add_left_q == LEN_W'(1) ? bus.adder_sum : result_q;
                res_stb_d  = add_left_q == LEN_W'(1);
                state_d    = add_left_q == LEN_W'(1) ? DONE : ISSUE;
            end
            DONE: if (res_xfer) begin
                res_stb_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Intake into the buffer overlaps adder work and may coincide with a result capture.
        if (accept && (state_q == ISSUE || state_q == WAIT)) begin
            buf_d       = bus.data_in;
            buf_full_d  = 1'b1;
            recv_left_d = recv_left_q - LEN_W'(1);
        end
        ctrl_busy_d = accept || !((state_d inside {FIRST, ISSUE, WAIT}) && !buf_full_d && recv_left_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            recv_left_q <= '0;
            add_left_q  <= '0;
            acc_q       <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            in_stb_q    <= 1'b0;
            mod_busy_q  <= 1'b1;
            ctrl_busy_q <= 1'b1;
            result_q    <= '0;
            res_stb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            recv_left_q <= recv_left_d;
            add_left_q  <= add_left_d;
            acc_q       <= acc_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            a_q         <= a_d;
            b_q         <= b_d;
            in_stb_q    <= in_stb_d;
            mod_busy_q  <= mod_busy_d;
            ctrl_busy_q <= ctrl_busy_d;
            result_q    <= result_d;
            res_stb_q   <= res_stb_d;
        end
    end

    assign bus.ctrl_BUSY         = ctrl_busy_q;
    assign bus.adder_a           = a_q;
    assign bus.adder_b           = b_q;
    assign bus.adder_input_STB   = in_stb_q;
    assign bus.adder_module_BUSY = mod_busy_q;
    assign bus.result            = result_q;
    assign bus.result_STB        = res_stb_q;

`ifdef FP32_ACC_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && bus.cmd_start))
            perf_q <= '0;
        else if (state_q != IDLE && perf_q != '1)
            perf_q <= perf_q + 32'd1;
    end
    assign bus.perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_fp32_accum_ctrl.sv
// tb_fp32_accum_ctrl: scoreboard bench with an integer-valued fp32 adder model and randomized handshakes.
module tb_fp32_accum_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp32_accum_ctrl_if bus();
    fp32_accum_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0, fails = 0;
    logic [31:0] exp_q[$], elem_q[$], sum_q[$];
    int accepted = 0, adder_txns = 0, results_seen = 0;
    bit in_stb_seen = 0, busy_low_seen = 0;
    bit hold_stb = 0, f_pend = 0, a_pend = 0, o_pend = 0, r_pend = 0;
    int stall = 0, lat = 0, busy_pct = 0, rbusy_pct = 0, res_hold = 0;
    logic [31:0] a_cap, b_cap, r_cap;

    function automatic logic [31:0] i2f(int v);
        int m, e;
        if (v == 0) return 32'h0;
        m = v < 0 ? -v : v;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        return {v < 0, 8'(127 + e), 23'((m << (23 - e)) & 32'h7FFFFF)};
    endfunction

    function automatic int f2i(logic [31:0] f);
        int e, m;
        if (f[30:23] == 8'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = int'({8'd0, 1'b1, f[22:0]}) >> (23 - e);
        return f[31] ? -m : m;
    endfunction

    // Reference: a fold of exactly representable integers is just their sum; len 1 passes bits verbatim.
    function automatic logic [31:0] ref_sum(int n, logic [31:0] e[$]);
        int s = 0;
        if (n == 0) return 32'h0;
        if (n == 1) return e[0];
        foreach (e[i]) s += f2i(e[i]);
        return i2f(s);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (f_pend) begin
            void'(elem_q.pop_front());
            accepted++;
            bus.data_in_STB = 1'b0;
        end
        if (!bus.data_in_STB && elem_q.size() > 0 && (hold_stb || $urandom_range(99) < 60)) begin
            bus.data_in_STB = 1'b1;
            bus.data_in = elem_q[0];
        end
        f_pend = bus.data_in_STB && !bus.ctrl_BUSY;
    end

    initial forever begin
        @(negedge clk);
        if (a_pend) begin
            sum_q.push_back(i2f(f2i(a_cap) + f2i(b_cap)));
            lat = $urandom_range(3);
            adder_txns++;
        end
        if (o_pend) bus.adder_output_STB = 1'b0;
        if (!bus.adder_output_STB && sum_q.size() > 0) begin
            if (lat > 0) lat--;
            else begin
                bus.adder_output_STB = 1'b1;
                bus.adder_sum = sum_q.pop_front();
            end
        end
        o_pend = bus.adder_output_STB && !bus.adder_module_BUSY;
        bus.adder_BUSY = stall > 0 ? 1'b1 : ($urandom_range(99) < busy_pct);
        if (stall > 0 && bus.adder_input_STB) stall--;
        a_pend = bus.adder_input_STB && !bus.adder_BUSY;
        a_cap = bus.adder_a;
        b_cap = bus.adder_b;
        if (bus.adder_input_STB) in_stb_seen = 1;
        if (!bus.ctrl_BUSY) busy_low_seen = 1;
    end

    initial forever begin
        @(negedge clk);
        if (r_pend) begin
            results_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h expected none", r_cap);
            end else chk("result", r_cap, exp_q.pop_front());
        end
        bus.result_module_BUSY = res_hold > 0 ? 1'b1 : ($urandom_range(99) < rbusy_pct);
        if (res_hold > 0 && bus.result_STB) res_hold--;
        r_pend = bus.result_STB && !bus.result_module_BUSY;
        r_cap = bus.result;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic run_cmd(int n, logic [31:0] e[$]);
        exp_q.push_back(ref_sum(n, e));
        foreach (e[i]) elem_q.push_back(e[i]);
        accepted = 0;
        cyc();
        bus.cmd_len = 8'(n);
        bus.cmd_start = 1'b1;
        cyc();
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_res(int target);
        int c = 0;
        while (results_seen < target && c < 3000) begin
            cyc();
            c++;
        end
        if (results_seen < target) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got %0d results, required %0d", results_seen, target);
        end
        repeat (3) cyc();
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_ctrl_BUSY"}, 32'(bus.ctrl_BUSY), 32'd1);
        chk({tag, "_in_STB"}, 32'(bus.adder_input_STB), 32'd0);
        chk({tag, "_mod_BUSY"}, 32'(bus.adder_module_BUSY), 32'd1);
        chk({tag, "_result_STB"}, 32'(bus.result_STB), 32'd0);
        chk({tag, "_result"}, bus.result, 32'd0);
        chk({tag, "_adder_ab"}, bus.adder_a | bus.adder_b, 32'd0);
    endtask

    initial begin
        int base, c;
        logic [31:0] e[$], held;
        bit stable;
        bus.cmd_start = 0; bus.cmd_len = 0; bus.data_in = 0; bus.data_in_STB = 0;
        bus.adder_BUSY = 0; bus.adder_sum = 0; bus.adder_output_STB = 0; bus.result_module_BUSY = 0;
        repeat (3) cyc();
        chk_reset_outputs("reset");
        rst = 1'b0;
        cyc();

        base = results_seen; adder_txns = 0; busy_pct = 30;
        run_cmd(3, '{32'h3F800000, 32'h40000000, 32'h40400000});
        wait_res(base + 1);
        chk("len3_txns", 32'(adder_txns), 32'd2);
        chk("len3_results", 32'(results_seen - base), 32'd1);

        base = results_seen; adder_txns = 0; busy_low_seen = 0; rbusy_pct = 0;
        e = {};
        run_cmd(0, e);
        chk("len0_result_STB_early", 32'(bus.result_STB), 32'd1);
        chk("len0_result_early", bus.result, 32'h0);
        wait_res(base + 1);
        chk("len0_txns", 32'(adder_txns), 32'd0);
        chk("len0_busy_low", 32'(busy_low_seen), 32'd0);

        base = results_seen; in_stb_seen = 0;
        run_cmd(1, '{32'hC0200000});
        wait_res(base + 1);
        chk("len1_in_STB_seen", 32'(in_stb_seen), 32'd0);
        chk("len1_accepted", 32'(accepted), 32'd1);

        base = results_seen; hold_stb = 1; stall = 5; busy_pct = 0;
        run_cmd(4, '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000});
        wait_res(base + 1);
        chk("len4_accepted", 32'(accepted), 32'd4);
        hold_stb = 0;

        base = results_seen; res_hold = 10; c = 0;
        run_cmd(2, '{i2f(5), i2f(7)});
        while (!bus.result_STB && c < 500) begin cyc(); c++; end
        held = bus.result;
        stable = bus.result_STB;
        repeat (9) begin
            cyc();
            if (!bus.result_STB || bus.result !== held) stable = 0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        wait_res(base + 1);
        chk("bp_results", 32'(results_seen - base), 32'd1);

        busy_pct = 20; c = 0;
        run_cmd(3, '{i2f(1), i2f(1), i2f(1)});
        while (bus.adder_module_BUSY && c < 500) begin cyc(); c++; end
        chk("reach_wait", 32'(bus.adder_module_BUSY), 32'd0);
        rst = 1'b1;
        exp_q.delete(); elem_q.delete(); sum_q.delete();
        bus.data_in_STB = 0; bus.adder_output_STB = 0;
        f_pend = 0; a_pend = 0; o_pend = 0; r_pend = 0;
        cyc();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        base = results_seen;
        run_cmd(2, '{32'h3F800000, 32'h3F800000});
        wait_res(base + 1);
        chk("postrst_results", 32'(results_seen - base), 32'd1);

        repeat (25) begin
            int n = $urandom_range(10);
            e = {};
            repeat (n) e.push_back(i2f(int'($urandom_range(2000)) - 1000));
            busy_pct = $urandom_range(50);
            rbusy_pct = $urandom_range(50);
            hold_stb = $urandom_range(1);
            base = results_seen;
            run_cmd(n, e);
            wait_res(base + 1);
            chk("rand_accepted", 32'(accepted), 32'(n));
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
